// File: rtl/music_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// music_pkg : shared widths, song table entry type and sequencer states
// Revision  : 1.0
// ----------------------------------------------------------------------------
package music_pkg;

  localparam int NOTE_W   = 2;
  localparam int REST_IDX = 3;
  localparam int DUR_W    = 6;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } song_entry_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PLAY  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// ----------------------------------------------------------------------------
// song_rom : constant song table, combinational read indexed by step
// Revision : 1.0
// ----------------------------------------------------------------------------
module song_rom
  import music_pkg::*;
#(
  parameter int SONG_LEN = 16,
  parameter int STEP_W   = $clog2(SONG_LEN)
) (
  input  logic [STEP_W-1:0] addr_i,
  output song_entry_t       entry_o
);

  // Any index without an explicit entry reads as an end-of-song marker.
  always_comb begin
    entry_o = '{note: '0, dur: '0};
    case (addr_i)
      STEP_W'(0): entry_o = '{note: NOTE_W'(0),        dur: DUR_W'(3)};
      STEP_W'(1): entry_o = '{note: NOTE_W'(2),        dur: DUR_W'(2)};
      STEP_W'(2): entry_o = '{note: NOTE_W'(REST_IDX), dur: DUR_W'(1)};
      default:    entry_o = '{note: '0, dur: '0};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// melody_sequencer : timed song playback driving the note mux select and mute
// Revision         : 1.0
// ----------------------------------------------------------------------------
module melody_sequencer #(
  parameter int CLK_HZ    = 25000000,
  parameter int TICK_HZ   = 64,
  parameter int NOTE_W    = 2,
  parameter int REST_IDX  = 3,
  parameter int SONG_LEN  = 16,
  parameter int DUR_W     = 6,
  parameter int GAP_TICKS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic                        loop_en_i,
  output logic [NOTE_W-1:0]           note_sel_o,
  output logic                        mute_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [$clog2(SONG_LEN)-1:0] step_o
);
  import music_pkg::*;

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int STEP_W = $clog2(SONG_LEN);
  localparam int GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SONG_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_TICKS);
  localparam logic [NOTE_W-1:0] REST_NOTE = NOTE_W'(REST_IDX);

  state_t              state_q;
  logic [PRE_W-1:0]    pre_q;
  logic [DUR_W-1:0]    dur_q;
  logic [GAP_W-1:0]    gap_q;
  logic [STEP_W-1:0]   step_q;
  logic                past_end_q;
  logic [NOTE_W-1:0]   note_q;
  logic                mute_q;
  logic                busy_q;
  logic                done_q;

  song_entry_t         rom_entry;
  logic                tick;
  logic                song_end;

  song_rom #(
    .SONG_LEN (SONG_LEN),
    .STEP_W   (STEP_W)
  ) u_song_rom (
    .addr_i  (step_q),
    .entry_o (rom_entry)
  );

  assign tick = (pre_q == PRE_LAST);
  // past_end_q marks running off the last table row so the step never wraps.
  assign song_end = past_end_q || (rom_entry.dur == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      dur_q      <= '0;
      gap_q      <= '0;
      step_q     <= '0;
      past_end_q <= 1'b0;
      note_q     <= '0;
      mute_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (stop_i) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      dur_q      <= '0;
      gap_q      <= '0;
      step_q     <= '0;
      past_end_q <= 1'b0;
      mute_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
          end
        end

        FETCH: begin
          if (song_end) begin
            if (loop_en_i) begin
              step_q     <= '0;
              past_end_q <= 1'b0;
              state_q    <= FETCH;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            note_q  <= rom_entry.note;
            mute_q  <= (rom_entry.note == REST_NOTE);
            dur_q   <= rom_entry.dur;
            pre_q   <= '0;
            state_q <= PLAY;
          end
        end

        PLAY: begin
          if (tick) begin
            pre_q <= '0;
            if (dur_q == DUR_W'(1)) begin
              mute_q <= 1'b1;
              if (GAP_TICKS > 0) begin
                gap_q   <= GAP_LOAD;
                state_q <= GAP;
              end else begin
                state_q <= FETCH;
                if (step_q == STEP_LAST) past_end_q <= 1'b1;
                else                     step_q     <= step_q + STEP_W'(1);
              end
            end else begin
              dur_q <= dur_q - DUR_W'(1);
            end
          end else begin
            pre_q <= pre_q + PRE_W'(1);
          end
        end

        GAP: begin
          if (tick) begin
            pre_q <= '0;
            if (gap_q == GAP_W'(1)) begin
              state_q <= FETCH;
              if (step_q == STEP_LAST) past_end_q <= 1'b1;
              else                     step_q     <= step_q + STEP_W'(1);
            end else begin
              gap_q <= gap_q - GAP_W'(1);
            end
          end else begin
            pre_q <= pre_q + PRE_W'(1);
          end
        end

        DONE: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          step_q     <= '0;
          past_end_q <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_sel_o = note_q;
  assign mute_o     = mute_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign step_o     = step_q;

endmodule
`default_nettype wire
